// File: rtl/upcnt_bcd_core_pkg.sv
// Shared types and constants for the 4-digit BCD elapsed-tick counter.
package upcnt_pkg;

  localparam int unsigned BCD_W      = 4;
  localparam int unsigned NUM_DIGITS = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  // Prescaler divide ratio; callers guarantee an integer result >= 2.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/upcnt_bcd_core_if.sv
// Control and digit-output bundle between the run/clear FSM and the counter.
interface upcnt_bcd_core_if;
  import upcnt_pkg::*;

  logic i_run_on;
  logic i_clr_on;
  bcd_t o_digit0;
  bcd_t o_digit1;
  bcd_t o_digit2;
  bcd_t o_digit3;
  logic o_tick;
  logic o_wrap;

  modport master (
    output i_run_on, i_clr_on,
    input  o_digit0, o_digit1, o_digit2, o_digit3, o_tick, o_wrap
  );

  modport slave (
    input  i_run_on, i_clr_on,
    output o_digit0, o_digit1, o_digit2, o_digit3, o_tick, o_wrap
  );

endinterface

// File: rtl/upcnt_bcd_core_bcd_decade.sv
// One BCD decade of the counter; carry out is combinational so a full
// ripple (e.g. 0999 -> 1000) settles within a single cycle.
module bcd_decade
  import upcnt_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_inc,
  output bcd_t o_digit,
  output logic o_carry
);

  logic at_top_c;

  // Out-of-range codes 10..15 behave like 9 so the decade self-recovers.
  assign at_top_c = (o_digit >= BCD_MAX);
  assign o_carry  = i_inc && at_top_c;

  // Digit register: clear wins, otherwise increment with roll-over.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_digit <= '0;
    end else if (i_clr) begin
      o_digit <= '0;
    end else if (i_inc) begin
      o_digit <= at_top_c ? bcd_t'(0) : o_digit + bcd_t'(1);
    end
  end

endmodule

// File: rtl/upcnt_bcd_core.sv
// 4-digit BCD elapsed-tick counter with built-in prescaler.
// Optional build macro UPCNT_SATURATE_EN: hold at 9999 instead of wrapping.
module upcnt_bcd_core
  import upcnt_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned TICK_HZ = 10
) (
  input logic              clk,
  input logic              reset,
  upcnt_bcd_core_if.slave  bus
);

  localparam int unsigned DIV     = calc_div(CLK_HZ, TICK_HZ);
  localparam int unsigned PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PRESC_W-1:0] presc_q;
  logic               tick_q;
  logic               wrap_q;

  logic run_c;
  logic tick_c;
  logic inc_c;
  logic tick_out_c;
  logic wrap_c;

  bcd_t digit0;
  bcd_t digit1;
  bcd_t digit2;
  bcd_t digit3;
  logic carry1;
  logic carry2;
  logic carry3;
  logic carry4;

  // Prescaler only moves on run cycles with no clear; terminal count is the tick.
  assign run_c  = bus.i_run_on && !bus.i_clr_on;
  assign tick_c = run_c && (presc_q == PRESC_W'(DIV - 1));

`ifdef UPCNT_SATURATE_EN
  logic at_max_c;
  logic sat_q;
  logic unused_carry_c;

  // At 9999 ticks are swallowed; wrap flags only the first swallowed tick.
  assign at_max_c       = (digit0 >= BCD_MAX) && (digit1 >= BCD_MAX) &&
                          (digit2 >= BCD_MAX) && (digit3 >= BCD_MAX);
  assign inc_c          = tick_c && !at_max_c;
  assign tick_out_c     = inc_c;
  assign wrap_c         = tick_c && at_max_c && !sat_q;
  assign unused_carry_c = carry4;

  // Remembers that saturation was already reported until the next clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_q <= 1'b0;
    end else if (bus.i_clr_on) begin
      sat_q <= 1'b0;
    end else if (wrap_c) begin
      sat_q <= 1'b1;
    end
  end
`else
  // Carry out of the thousands decade is exactly the 9999 -> 0000 event.
  assign inc_c      = tick_c;
  assign tick_out_c = tick_c;
  assign wrap_c     = carry4;
`endif

  // Prescaler register: clear wins, pauses hold the current phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
    end else if (bus.i_clr_on) begin
      presc_q <= '0;
    end else if (run_c) begin
      presc_q <= tick_c ? '0 : presc_q + PRESC_W'(1);
    end
  end

  // Registered event pulses, aligned with the new digit value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      tick_q <= tick_out_c;
      wrap_q <= wrap_c;
    end
  end

  bcd_decade u_dec0 (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (bus.i_clr_on),
    .i_inc   (inc_c),
    .o_digit (digit0),
    .o_carry (carry1)
  );

  bcd_decade u_dec1 (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (bus.i_clr_on),
    .i_inc   (carry1),
    .o_digit (digit1),
    .o_carry (carry2)
  );

  bcd_decade u_dec2 (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (bus.i_clr_on),
    .i_inc   (carry2),
    .o_digit (digit2),
    .o_carry (carry3)
  );

  bcd_decade u_dec3 (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (bus.i_clr_on),
    .i_inc   (carry3),
    .o_digit (digit3),
    .o_carry (carry4)
  );

  assign bus.o_digit0 = digit0;
  assign bus.o_digit1 = digit1;
  assign bus.o_digit2 = digit2;
  assign bus.o_digit3 = digit3;
  assign bus.o_tick   = tick_q;
  assign bus.o_wrap   = wrap_q;

endmodule

// File: tb/tb_upcnt_bcd_core.sv
// Scoreboard bench for upcnt_bcd_core: a DIV=10 instance for the main plan
// and a DIV=2 instance so the 9999 boundary is reached in few cycles.
module tb_upcnt_bcd_core;
  import upcnt_pkg::*;

  typedef struct packed {
    logic [15:0] digits;
    logic        tick;
    logic        wrap;
  } exp_t;

  logic clk;
  logic reset;

  upcnt_bcd_core_if bus0 ();
  upcnt_bcd_core_if bus1 ();

  upcnt_bcd_core #(.CLK_HZ(10), .TICK_HZ(1)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  upcnt_bcd_core #(.CLK_HZ(2), .TICK_HZ(1)) u_dut_fast (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  exp_t q0 [$];
  exp_t q1 [$];

  // Reference model: elapsed count as an integer plus run-cycle accumulator.
  int unsigned m_div   [2];
  int unsigned m_count [2];
  int unsigned m_presc [2];
  bit          m_sat   [2];

  logic run_v [2];
  logic clr_v [2];

  logic [15:0] act_d [2];
  logic        act_t [2];
  logic        act_w [2];

  always_comb begin
    act_d[0] = {bus0.o_digit3, bus0.o_digit2, bus0.o_digit1, bus0.o_digit0};
    act_t[0] = bus0.o_tick;
    act_w[0] = bus0.o_wrap;
    act_d[1] = {bus1.o_digit3, bus1.o_digit2, bus1.o_digit1, bus1.o_digit0};
    act_t[1] = bus1.o_tick;
    act_w[1] = bus1.o_wrap;
  end

  function automatic logic [15:0] bcd16(input int unsigned c);
    return {4'((c / 1000) % 10), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  task automatic model_step(input int k, output exp_t e);
    logic t;
    logic w;
    t = 1'b0;
    w = 1'b0;
    if (!reset || clr_v[k]) begin
      m_count[k] = 0;
      m_presc[k] = 0;
      m_sat[k]   = 1'b0;
    end else if (run_v[k]) begin
      m_presc[k] += 1;
      if (m_presc[k] == m_div[k]) begin
        m_presc[k] = 0;
`ifdef UPCNT_SATURATE_EN
        if (m_count[k] == 9999) begin
          w        = !m_sat[k];
          m_sat[k] = 1'b1;
        end else begin
          m_count[k] += 1;
          t = 1'b1;
        end
`else
        m_count[k] = (m_count[k] + 1) % 10000;
        t = 1'b1;
        w = (m_count[k] == 0);
`endif
      end
    end
    e.digits = bcd16(m_count[k]);
    e.tick   = t;
    e.wrap   = w;
  endtask

  task automatic sb_cmp(input int k, input exp_t e);
    n_tests++;
    if (act_d[k] !== e.digits || act_t[k] !== e.tick || act_w[k] !== e.wrap) begin
      n_fail++;
      $display("FAIL sb_inst%0d @%0t: got digits=%h tick=%b wrap=%b, expected digits=%h tick=%b wrap=%b",
               k, $time, act_d[k], act_t[k], act_w[k], e.digits, e.tick, e.wrap);
    end
  endtask

  // Monitor: every cycle is an output beat; compare against queued expectation.
  always @(posedge clk) begin
    #1;
    if (q0.size() != 0) sb_cmp(0, q0.pop_front());
    if (q1.size() != 0) sb_cmp(1, q1.pop_front());
  end

  task automatic chk(input string name, input int k, input int unsigned cnt,
                     input logic t, input logic w);
    n_tests++;
    if (act_d[k] !== bcd16(cnt) || act_t[k] !== t || act_w[k] !== w) begin
      n_fail++;
      $display("FAIL %s: got digits=%h tick=%b wrap=%b, expected digits=%h tick=%b wrap=%b",
               name, act_d[k], act_t[k], act_w[k], bcd16(cnt), t, w);
    end
  endtask

  // One clock: drive inputs away from the edge, queue expectation, pass the edge.
  task automatic cyc();
    exp_t e0;
    exp_t e1;
    bus0.i_run_on = run_v[0];
    bus0.i_clr_on = clr_v[0];
    bus1.i_run_on = run_v[1];
    bus1.i_clr_on = clr_v[1];
    model_step(0, e0);
    model_step(1, e1);
    q0.push_back(e0);
    q1.push_back(e1);
    @(posedge clk);
    #2;
  endtask

  task automatic run_until(input int k, input int unsigned target, input int unsigned budget);
    int unsigned n;
    n = 0;
    run_v[k] = 1'b1;
    clr_v[k] = 1'b0;
    while (m_count[k] != target && n < budget) begin
      cyc();
      n++;
    end
    chk($sformatf("reach_%0d_inst%0d", target, k), k, target, 1'b1, 1'b0);
  endtask

  initial begin
    int unsigned n_hold;
    m_div[0] = 10;
    m_div[1] = 2;
    for (int k = 0; k < 2; k++) begin
      m_count[k] = 0;
      m_presc[k] = 0;
      m_sat[k]   = 1'b0;
      run_v[k]   = 1'b0;
      clr_v[k]   = 1'b0;
    end
    bus0.i_run_on = 1'b0;
    bus0.i_clr_on = 1'b0;
    bus1.i_run_on = 1'b0;
    bus1.i_clr_on = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("reset_init_inst0", 0, 0, 1'b0, 1'b0);
    chk("reset_init_inst1", 1, 0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    run_v[0] = 1'b1;
    repeat (2) cyc();
    chk("reset_hold_with_run", 0, 0, 1'b0, 1'b0);
    reset = 1'b1;

    // Run 25 cycles: ticks on cycles 10 and 20.
    for (int i = 1; i <= 25; i++) begin
      cyc();
      if (i == 9)  chk("run_c9",  0, 0, 1'b0, 1'b0);
      if (i == 10) chk("run_c10", 0, 1, 1'b1, 1'b0);
      if (i == 11) chk("run_c11", 0, 1, 1'b0, 1'b0);
      if (i == 20) chk("run_c20", 0, 2, 1'b1, 1'b0);
    end
    chk("run_25", 0, 2, 1'b0, 1'b0);

    // Pause/resume with held prescaler = 7: tick on third resumed cycle.
    run_until(0, 95, 2000);
    repeat (7) cyc();
    run_v[0] = 1'b0;
    repeat (7) cyc();
    chk("stop_hold_95", 0, 95, 1'b0, 1'b0);
    run_v[0] = 1'b1;
    cyc();
    chk("resume_1", 0, 95, 1'b0, 1'b0);
    cyc();
    chk("resume_2", 0, 95, 1'b0, 1'b0);
    cyc();
    chk("resume_3_tick", 0, 96, 1'b1, 1'b0);

    // Pause/resume with random held prescaler < 7: no tick.
    run_until(0, 97, 100);
    n_hold = $urandom_range(0, 6);
    repeat (n_hold) cyc();
    run_v[0] = 1'b0;
    repeat ($urandom_range(1, 10)) cyc();
    run_v[0] = 1'b1;
    repeat (3) cyc();
    chk("resume_no_tick", 0, 97, 1'b0, 1'b0);

    // Randomised run toggling with occasional clears on both instances.
    repeat (400) begin
      run_v[0] = 1'($urandom_range(0, 1));
      clr_v[0] = ($urandom_range(0, 31) == 0);
      run_v[1] = 1'($urandom_range(0, 1));
      clr_v[1] = ($urandom_range(0, 31) == 0);
      cyc();
    end
    run_v = '{1'b0, 1'b0};
    clr_v = '{1'b1, 1'b1};
    cyc();
    chk("clear_inst0", 0, 0, 1'b0, 1'b0);
    chk("clear_inst1", 1, 0, 1'b0, 1'b0);
    clr_v = '{1'b0, 1'b0};

    // Clear has priority over run and zeroes the prescaler.
    run_until(0, 42, 1000);
    run_v[0] = 1'b1;
    clr_v[0] = 1'b1;
    cyc();
    chk("clr_prio", 0, 0, 1'b0, 1'b0);
    repeat (20) cyc();
    chk("clr_hold_20", 0, 0, 1'b0, 1'b0);
    clr_v[0] = 1'b0;
    repeat (9) cyc();
    chk("after_clr_c9", 0, 0, 1'b0, 1'b0);
    cyc();
    chk("after_clr_c10", 0, 1, 1'b1, 1'b0);

    // Carry ripple: 0019 -> 0020 and 0999 -> 1000.
    run_until(0, 19, 500);
    run_until(0, 20, 20);
    run_until(0, 999, 20000);
    run_until(0, 1000, 20);

    // Asynchronous reset mid-prescale (prescaler 5, count 0003).
    clr_v[0] = 1'b1;
    cyc();
    run_until(0, 3, 100);
    repeat (5) cyc();
    chk("pre_reset_3", 0, 3, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    chk("async_reset_inst0", 0, 0, 1'b0, 1'b0);
    chk("async_reset_inst1", 1, 0, 1'b0, 1'b0);
    repeat (2) cyc();
    reset = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      if (i == 9)  chk("post_reset_c9",  0, 0, 1'b0, 1'b0);
      if (i == 10) chk("post_reset_c10", 0, 1, 1'b1, 1'b0);
    end

    // 9999 boundary on the fast instance.
    run_v[0] = 1'b0;
    clr_v[1] = 1'b1;
    cyc();
    run_until(1, 9999, 25000);
    run_v[1] = 1'b1;
    cyc();
    chk("pre_wrap", 1, 9999, 1'b0, 1'b0);
    cyc();
`ifdef UPCNT_SATURATE_EN
    chk("sat_block", 1, 9999, 1'b0, 1'b1);
    repeat (4) cyc();
    chk("sat_hold", 1, 9999, 1'b0, 1'b0);
`else
    chk("wrap", 1, 0, 1'b1, 1'b1);
    cyc();
    chk("wrap_pulse_end", 1, 0, 1'b0, 1'b0);
    cyc();
    chk("after_wrap", 1, 1, 1'b1, 1'b0);
`endif
    clr_v[1] = 1'b1;
    cyc();
    clr_v[1] = 1'b0;
    repeat (2) cyc();
    chk("clr_restore", 1, 1, 1'b1, 1'b0);

    run_v = '{1'b0, 1'b0};
    cyc();
    @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
